// File: rtl/mac_enc.sv
// mac_enc: transmit-side frame re-assembler.
//   Pops one header word, writes the 14 header bytes (dst MAC, src MAC,
//   EtherType, MSB first), then copies body bytes up to EOD. Short frames are
//   zero-padded to MIN_LEN. Long bodies are truncated at MAX_LEN and the rest
//   is drained. A header carrying the error flag drains its body without
//   writing anything.
//
//   Read strobes are registered. Both input FIFOs present their head word on
//   dout while the strobe is high and pop it at that clock edge. The word is
//   therefore consumed in the cycle after the FSM decides to read: HLOAD for
//   the header FIFO, BWAIT or the second DRAIN phase for the body FIFO.
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   h_fifo_dout/empty/rden            header FIFO (115-bit words)
//   b_fifo_dout/empty/del/rden        body FIFO (bytes + EOD tag)
//   o_fifo_din/wren/del/afull         output packet FIFO
//   o_port                            ingress port of the current frame
//   busy, frame_done, err             status
module mac_enc #(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514,
  parameter int CNT_W   = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [114:0] h_fifo_dout,
  input  logic         h_fifo_empty,
  output logic         h_fifo_rden,
  input  logic [7:0]   b_fifo_dout,
  input  logic         b_fifo_empty,
  input  logic         b_fifo_del,
  output logic         b_fifo_rden,
  output logic [7:0]   o_fifo_din,
  output logic         o_fifo_wren,
  output logic         o_fifo_del,
  input  logic         o_fifo_afull,
  output logic [1:0]   o_port,
  output logic         busy,
  output logic         frame_done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HLOAD, S_HDR, S_BREQ, S_BWAIT, S_PAD, S_DRAIN
  } state_e;

  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(13);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_LEN);

  state_e             state_q, state_d;
  logic               drn_rd_q, drn_rd_d;   // DRAIN: a body read is in flight
  logic [111:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               h_rden_q, h_rden_d;
  logic               b_rden_q, b_rden_d;
  logic [7:0]         din_q, din_d;
  logic               wren_q, wren_d;
  logic               del_q, del_d;
  logic [1:0]         port_q, port_d;
  logic               busy_q, busy_d;
  logic               fdone_q, fdone_d;
  logic               err_q, err_d;

  logic [CNT_W-1:0]   cnt_inc;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // State register (and all other registers).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      drn_rd_q <= 1'b0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      h_rden_q <= 1'b0;
      b_rden_q <= 1'b0;
      din_q    <= '0;
      wren_q   <= 1'b0;
      del_q    <= 1'b0;
      port_q   <= '0;
      busy_q   <= 1'b0;
      fdone_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      drn_rd_q <= drn_rd_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      h_rden_q <= h_rden_d;
      b_rden_q <= b_rden_d;
      din_q    <= din_d;
      wren_q   <= wren_d;
      del_q    <= del_d;
      port_q   <= port_d;
      busy_q   <= busy_d;
      fdone_q  <= fdone_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    drn_rd_d = drn_rd_q;
    case (state_q)
      S_IDLE:  if (!h_fifo_empty) state_d = S_HLOAD;
      S_HLOAD: begin
        state_d  = h_fifo_dout[0] ? S_DRAIN : S_HDR;
        drn_rd_d = 1'b0;
      end
      S_HDR:   if (!o_fifo_afull && cnt_q == HDR_LAST) state_d = S_BREQ;
      S_BREQ:  if (!b_fifo_empty && !o_fifo_afull) state_d = S_BWAIT;
      S_BWAIT: begin
        if (b_fifo_del)            state_d = (cnt_inc >= MIN_C) ? S_IDLE : S_PAD;
        else if (cnt_inc == MAX_C) begin
          state_d  = S_DRAIN;
          drn_rd_d = 1'b0;
        end else                   state_d = S_BREQ;
      end
      S_PAD:   if (!o_fifo_afull && cnt_inc == MIN_C) state_d = S_IDLE;
      S_DRAIN: begin
        if (!drn_rd_q) begin
          if (!b_fifo_empty) drn_rd_d = 1'b1;
        end else begin
          drn_rd_d = 1'b0;
          if (b_fifo_del) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    h_rden_d = 1'b0;
    b_rden_d = 1'b0;
    din_d    = 8'h00;
    wren_d   = 1'b0;
    del_d    = 1'b0;
    fdone_d  = 1'b0;
    err_d    = 1'b0;
    port_d   = port_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    busy_d   = (state_d != S_IDLE);
    case (state_q)
      S_IDLE:  h_rden_d = !h_fifo_empty;
      S_HLOAD: begin
        shreg_d = h_fifo_dout[114:3];
        port_d  = h_fifo_dout[2:1];
        cnt_d   = '0;
        err_d   = h_fifo_dout[0];
      end
      S_HDR: begin
        if (!o_fifo_afull) begin
          wren_d  = 1'b1;
          din_d   = shreg_q[111:104];
          shreg_d = {shreg_q[103:0], 8'h00};
          cnt_d   = cnt_inc;
        end
      end
      S_BREQ:  b_rden_d = (state_d == S_BWAIT);
      S_BWAIT: begin
        // afull was checked in BREQ; the FIFO margin absorbs this write.
        wren_d = 1'b1;
        din_d  = b_fifo_dout;
        cnt_d  = cnt_inc;
        if (b_fifo_del) begin
          if (cnt_inc >= MIN_C) begin
            del_d   = 1'b1;
            fdone_d = 1'b1;
          end
        end else if (cnt_inc == MAX_C) begin
          del_d   = 1'b1;
          fdone_d = 1'b1;
          err_d   = 1'b1;
        end
      end
      S_PAD: begin
        if (!o_fifo_afull) begin
          wren_d = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == MIN_C) begin
            del_d   = 1'b1;
            fdone_d = 1'b1;
          end
        end
      end
      S_DRAIN: b_rden_d = !drn_rd_q && !b_fifo_empty;
      default: ;
    endcase
  end

  assign h_fifo_rden = h_rden_q;
  assign b_fifo_rden = b_rden_q;
  assign o_fifo_din  = din_q;
  assign o_fifo_wren = wren_q;
  assign o_fifo_del  = del_q;
  assign o_port      = port_q;
  assign busy        = busy_q;
  assign frame_done  = fdone_q;
  assign err         = err_q;

endmodule

// File: doc/mac_enc.md
Name: mac_enc

Overview:
- Frame re-assembler, the transmit-side counterpart of the MAC decoder.
- Pops one 115-bit header word from the header FIFO and emits the 14 Ethernet header bytes (destination MAC, source MAC, EtherType) into an output packet FIFO.
- Then copies the matching body bytes from the body packet FIFO until end-of-data (EOD), zero-pads the frame to the minimum length, and marks the last byte with `o_fifo_del`.
- Sits between the header/body FIFO pair and the per-port TX packet FIFOs. FCS is appended downstream.

Parameters:
- `MIN_LEN`, 60: minimum frame bytes written, header included, FCS excluded.
- `MAX_LEN`, 1514: maximum frame bytes written, header included.
- `CNT_W`, 11: width of the byte counter. Must satisfy 2^`CNT_W` > `MAX_LEN`.

Ports:
- `clk` input 1: system clock, 100 MHz.
- `rst_n` input 1: synchronous active-low reset.
- `h_fifo_dout` input 115: header word. Bit layout:
  - [114:67] destination MAC
  - [66:19] source MAC
  - [18:3] EtherType
  - [2:1] ingress port
  - [0] error flag
- `h_fifo_empty` input 1: header FIFO empty.
- `h_fifo_rden` output 1: header FIFO read strobe. `h_fifo_dout` is valid 1 cycle after the strobe.
- `b_fifo_dout` input 8: body byte. Valid 1 cycle after `b_fifo_rden`.
- `b_fifo_empty` input 1: body FIFO empty.
- `b_fifo_del` input 1: EOD tag for the byte on `b_fifo_dout`. Valid in the same cycle as that byte.
- `b_fifo_rden` output 1: body FIFO read strobe.
- `o_fifo_din` output 8: output byte.
- `o_fifo_wren` output 1: output write strobe.
- `o_fifo_del` output 1: EOD tag. Asserted with `o_fifo_wren` on the last byte of a frame.
- `o_fifo_afull` input 1: output FIFO almost full.
- `o_port` output 2: ingress port of the current frame. Held from HLOAD until the next HLOAD.
- `busy` output 1: high in every state except IDLE.
- `frame_done` output 1: 1-cycle pulse in the cycle the `o_fifo_del` byte is written.
- `err` output 1: 1-cycle pulse on DRAIN entry or on truncation.

Behaviour:
- Reset (`rst_n` = 0 at a `clk` edge):
  - All outputs go to 0, the state goes to IDLE and the counter is cleared.
  - Reset mid-frame abandons the frame without writing `o_fifo_del`. Upstream FIFOs are reset by the same system reset.
- All outputs are registered.
- States: IDLE, HLOAD, HDR, BREQ, BWAIT, PAD, DRAIN.
- IDLE: if `h_fifo_empty` = 0, assert `h_fifo_rden` for 1 cycle and go to HLOAD.
- HLOAD:
  - Latch `h_fifo_dout` into a 112-bit shift register, latch `o_port`, clear the counter.
  - Error flag = 1: go to DRAIN. Otherwise go to HDR.
- HDR:
  - Each cycle with `o_fifo_afull` = 0: write the shift-register MSB byte (destination MAC first, most significant byte first), shift left 8, increment the counter.
  - After 14 bytes, go to BREQ.
  - `o_fifo_afull` = 1 stalls with no write.
- BREQ: if `b_fifo_empty` = 0 and `o_fifo_afull` = 0, assert `b_fifo_rden` and go to BWAIT. Otherwise stall.
- BWAIT: write `b_fifo_dout` and increment the counter. One body read is outstanding at most, so body throughput is 1 byte per 2 cycles. Then:
  - `b_fifo_del` = 1 and counter+1 ≥ `MIN_LEN`: set `o_fifo_del`, pulse `frame_done`, go to IDLE.
  - `b_fifo_del` = 1 and counter+1 < `MIN_LEN`: go to PAD without `o_fifo_del`.
  - `b_fifo_del` = 0 and counter+1 = `MAX_LEN`: set `o_fifo_del`, pulse `frame_done` and `err`, go to DRAIN (truncation).
  - Otherwise: go to BREQ.
- PAD:
  - Each cycle with `o_fifo_afull` = 0: write 0x00 and increment the counter.
  - On the byte where the counter reaches `MIN_LEN`: set `o_fifo_del`, pulse `frame_done`, go to IDLE.
- DRAIN:
  - Read body bytes using the same BREQ/BWAIT alternation. `o_fifo_afull` is ignored and no writes occur.
  - Leave to IDLE in the cycle after the byte with `b_fifo_del` = 1 is read.
  - `err` pulses once on DRAIN entry.
- Each header word pairs with exactly one EOD-terminated body.
- Strobe hazards:
  - `h_fifo_rden` is never asserted outside IDLE.
  - `b_fifo_rden` is never asserted while empty.
  - `o_fifo_wren` is never asserted in a cycle where it was sampled with `o_fifo_afull` = 1. The BWAIT write is permitted because afull was checked at BREQ; the afull margin must be ≥ 2.
- Back-to-back frames: IDLE is re-entered for at least 1 cycle between frames.

Test Plan:
- Header dst=FF:FF:FF:FF:FF:FF, src=00:11:22:33:44:55, type=0x0800, port=2, err=0; body 46 bytes 0x01..0x2E with EOD on the last -> 60 writes:
  - bytes 0–5 = FF, bytes 6–11 = 00..55, bytes 12–13 = 08 00, then 01..2E;
  - `o_fifo_del` on write 60 only; `o_port` = 2; `frame_done` = 1 pulse.
- Body of 3 bytes AA BB CC -> 17 data bytes followed by 43 bytes of 0x00; `o_fifo_del` on write 60 only.
- Header with err=1 and a 10-byte body -> zero `o_fifo_wren`; 10 `b_fifo_rden`; `err` = 1 pulse; returns to IDLE.
- Body of 1600 bytes with no early EOD -> 1514 writes, del on write 1514; `err` pulse; remaining 100 body bytes drained with no writes.
- Hold `o_fifo_afull` = 1 for 20 cycles during HDR and again during BREQ -> no writes while held; output byte sequence identical to the unstalled run.
- Assert `rst_n` = 0 mid-body, then feed a new header and body -> all outputs 0 the cycle after reset; the next frame is emitted correctly.
